// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the oversampling UART.
// Used by uart_rx_os and the planned uart_tx_os.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  function automatic logic majority3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: CLK_DIV clock divider producing a one-cycle
// sample tick, held at zero while disabled or cleared.
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote sampling,
// configurable framing and a valid/ready output with error flags.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  import uart_pkg::*;

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] P_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  uart_state_e state_q, state_d;

  logic                 sync1_q, sync2_q;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bc_q, bc_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  logic rxs, tick, vote, dec, ld, fe_fin, idle;

  assign rxs  = sync2_q;
  assign idle = (state_q == ST_IDLE);
  // vote over the two previous samples and the current one
  assign vote = majority3(smp_q[1], smp_q[0], rxs);

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (!idle),
    .clr_i  (idle),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!rxs) state_d = ST_START;
      ST_START:  if (dec) state_d = vote ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (dec && bc_q == B_LAST) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (dec) state_d = ST_STOP;
      ST_STOP: begin
        if (dec && bc_q == P_LAST) begin
          state_d = fe_fin ? ST_BREAK : ST_IDLE;
        end
      end
      ST_BREAK:  if (rxs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dec    = 1'b0;
    ld     = 1'b0;
    fe_fin = fe_q | ~vote;
    unique case (1'b1)
      (state_q == ST_START): dec = tick && (s_q == S_MID);
      (state_q == ST_DATA),
      (state_q == ST_PARITY): dec = tick && (s_q == S_END);
      (state_q == ST_STOP): begin
        dec = tick && (s_q == S_END);
        ld  = dec && (bc_q == P_LAST);
      end
      default: dec = 1'b0;
    endcase
  end

  always_comb begin
    s_d   = s_q;
    bc_d  = bc_q;
    smp_d = smp_q;
    sh_d  = sh_q;
    pe_d  = pe_q;
    fe_d  = fe_q;
    if (idle || state_q == ST_BREAK) begin
      s_d   = '0;
      bc_d  = '0;
      smp_d = 2'b11;
    end else if (tick) begin
      smp_d = {smp_q[0], rxs};
      s_d   = dec ? '0 : s_q + 1'b1;
      if (dec) begin
        unique case (state_q)
          ST_START: begin
            bc_d = '0;
            pe_d = 1'b0;
            fe_d = 1'b0;
          end
          ST_DATA: begin
            sh_d = {vote, sh_q[DATA_BITS-1:1]};
            bc_d = (bc_q == B_LAST) ? '0 : bc_q + 1'b1;
          end
          ST_PARITY: pe_d = (^sh_q) ^ vote ^ ODD;
          ST_STOP: begin
            fe_d = fe_fin;
            bc_d = (bc_q == P_LAST) ? '0 : bc_q + 1'b1;
          end
          default: bc_d = bc_q;
        endcase
      end
    end
  end

  // a load in a transfer cycle replaces the word without overrun
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    if (ld) begin
      data_d  = sh_q;
      ferr_d  = fe_fin;
      perr_d  = pe_q;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (ld && valid_q && !rx_ready) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      s_q     <= '0;
      bc_q    <= '0;
      smp_q   <= 2'b11;
      sh_q    <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      s_q     <= s_d;
      bc_q    <= bc_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench driving three receiver
// configurations (8N1, 8E1, 7O2) with serial frames.
module tb_uart_rx_os;

  localparam int BP = 64;

  typedef struct {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_ready = 1'b1;
  logic       clr_overrun = 1'b0;
  logic [2:0] rxd_v = 3'b111;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       v0, v1, v2;
  logic       fe0, fe1, fe2;
  logic       pe0, pe1, pe2;
  logic       ov0, ov1, ov2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   dcnt[3] = '{0, 0, 0};
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_os u_8n1 (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_v[0]),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
    .clr_overrun(clr_overrun)
  );

  uart_rx_os #(.PARITY_EN(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_v[1]),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rx_ready),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
    .clr_overrun(clr_overrun)
  );

  uart_rx_os #(
    .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) u_7o2 (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_v[2]),
    .rx_data(d2), .rx_valid(v2), .rx_ready(rx_ready),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2),
    .clr_overrun(clr_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsz(input int ln);
    case (ln)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int ln, input exp_t e);
    case (ln)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int ln, input logic [8:0] d,
                     input logic fe, input logic pe);
    exp_t e;
    dcnt[ln]++;
    chk($sformatf("expect%0d", ln), qsz(ln) != 0, 1);
    if (qsz(ln) != 0) begin
      case (ln)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("data%0d", ln), d, e.d);
      chk($sformatf("fe%0d", ln), fe, e.fe);
      chk($sformatf("pe%0d", ln), pe, e.pe);
    end
  endtask

  always @(negedge clk) if (v0 && rx_ready) mon(0, {1'b0, d0}, fe0, pe0);
  always @(negedge clk) if (v1 && rx_ready) mon(1, {1'b0, d1}, fe1, pe1);
  always @(negedge clk) if (v2 && rx_ready) mon(2, {2'b0, d2}, fe2, pe2);

  task automatic drive(input int ln, input logic v, input int nbits);
    rxd_v[ln] = v;
    repeat (nbits * BP) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ln, input logic [8:0] d, input int nb,
                      input bit pen, input bit podd, input int ns,
                      input bit flip, input logic [1:0] stv,
                      input bit psh);
    exp_t e;
    logic [8:0] dm;
    logic pb;
    dm = d & ((9'd1 << nb) - 9'd1);
    pb = (^dm) ^ podd ^ flip;
    e.d  = dm;
    e.fe = !stv[0] || (ns == 2 && !stv[1]);
    e.pe = pen && flip;
    if (psh) push(ln, e);
    drive(ln, 1'b0, 1);
    for (int i = 0; i < nb; i++) drive(ln, dm[i], 1);
    if (pen) drive(ln, pb, 1);
    for (int i = 0; i < ns; i++) drive(ln, stv[i], 1);
  endtask

  task automatic wait_q(input int ln);
    for (int i = 0; i < 4000 && qsz(ln) != 0; i++) @(posedge clk);
    chk($sformatf("q_empty%0d", ln), qsz(ln), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n, lat;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_pe", pe0, 0);
    chk("rst_ovr", ov0, 0);
    @(posedge clk);
    #1;

    lat = 0;
    fork
      send(0, 9'hA5, 8, 0, 0, 1, 0, 2'b11, 1);
      begin
        while (!v0 && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("latency_win", (lat >= 605 && lat <= 617), 1);
    drive(0, 1'b1, 1);
    wait_q(0);

    send(1, 9'h3C, 8, 1, 0, 1, 0, 2'b11, 1);
    drive(1, 1'b1, 1);
    send(1, 9'h3C, 8, 1, 0, 1, 1, 2'b11, 1);
    drive(1, 1'b1, 1);
    wait_q(1);

    n = dcnt[0];
    rxd_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd_v[0] = 1'b1;
    drive(0, 1'b1, 2);
    chk("glitch_none", dcnt[0] - n, 0);
    send(0, 9'h55, 8, 0, 0, 1, 0, 2'b11, 1);
    drive(0, 1'b1, 1);
    wait_q(0);

    n = dcnt[0];
    send(0, 9'h96, 8, 0, 0, 1, 0, 2'b00, 1);
    drive(0, 1'b0, 3);
    chk("brk_one", dcnt[0] - n, 1);
    drive(0, 1'b1, 2);
    chk("brk_after", dcnt[0] - n, 1);
    wait_q(0);

    rx_ready = 1'b0;
    send(0, 9'h11, 8, 0, 0, 1, 0, 2'b11, 0);
    drive(0, 1'b1, 1);
    send(0, 9'h22, 8, 0, 0, 1, 0, 2'b11, 1);
    drive(0, 1'b1, 1);
    chk("ovr_set", ov0, 1);
    chk("ovr_valid", v0, 1);
    chk("ovr_data", d0, 8'h22);
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_sticky", ov0, 1);
    chk("valid_drop", v0, 0);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    @(negedge clk);
    chk("ovr_clr", ov0, 0);
    wait_q(0);

    n = dcnt[0];
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 2);
    reset_n = 1'b0;
    rxd_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_valid", v0, 0);
    drive(0, 1'b1, 2);
    send(0, 9'h0F, 8, 0, 0, 1, 0, 2'b11, 1);
    drive(0, 1'b1, 1);
    wait_q(0);
    chk("abort_count", dcnt[0] - n, 1);

    send(2, 9'h7F, 7, 1, 1, 2, 0, 2'b11, 1);
    drive(2, 1'b1, 1);
    send(2, 9'h7F, 7, 1, 1, 2, 1, 2'b11, 1);
    drive(2, 1'b1, 1);
    send(2, 9'h2A, 7, 1, 1, 2, 0, 2'b01, 1);
    drive(2, 1'b1, 2);
    send(2, 9'h15, 7, 1, 1, 2, 0, 2'b11, 1);
    drive(2, 1'b1, 1);
    wait_q(2);

    chk("lane1_count", dcnt[1], 2);
    chk("lane2_count", dcnt[2], 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
